// File: rtl/dkong_hiscore_xfer.sv
// High-score side-port initiator: copies the score region between game RAM and the
// save-file buffer while the framework holds the CPU paused.
module dkong_hiscore_xfer #(
  parameter logic [15:0] HS_BASE  = 16'h6100,
  parameter logic [9:0]  HS_LEN   = 10'd64,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESETn,
  input  logic        I_SAVE_REQ,
  input  logic        I_LOAD_REQ,
  input  logic        I_PAUSED,
  output logic        O_PAUSE_REQ,
  output logic [15:0] O_HS_ADDR,
  output logic [7:0]  O_HS_DI,
  output logic        O_HS_WE,
  output logic        O_HS_ACCESS,
  input  logic [7:0]  I_HS_DO,
  output logic [9:0]  O_BUF_ADDR,
  output logic        O_BUF_WE,
  output logic [7:0]  O_BUF_D,
  input  logic [7:0]  I_BUF_Q,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_ERR
);

  typedef enum logic [2:0] {
    StIdle, StPwait, StSAddr, StSWait, StSStore, StLFetch, StLWrite, StFin
  } state_e;

  // Value of the wait counter in the last S_WAIT cycle (S_WAIT lasts READ_LAT-1 cycles).
  localparam logic [1:0] WaitLast = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_e      state_q;
  logic        load_q;
  logic [9:0]  idx_q;
  logic [1:0]  wait_q;
  logic        pause_req_q;
  logic        hs_access_q;
  logic        hs_we_q;
  logic [15:0] hs_addr_q;
  logic [7:0]  hs_di_q;
  logic [9:0]  buf_addr_q;
  logic        buf_we_q;
  logic [7:0]  buf_d_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic [9:0]  idx_next;
  logic        last_byte;
  logic        pause_lost;
  logic        store_now;

  always_comb begin
    idx_next   = idx_q + 10'd1;
    last_byte  = (idx_next == HS_LEN);
    pause_lost = !I_PAUSED &&
                 (state_q inside {StSAddr, StSWait, StSStore, StLFetch, StLWrite});
    // Read data is valid on the edge ending the READ_LAT-th cycle after the address.
    store_now  = ((state_q == StSAddr) && (READ_LAT == 1)) ||
                 ((state_q == StSWait) && (wait_q == WaitLast));
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q     <= StIdle;
      load_q      <= 1'b0;
      idx_q       <= '0;
      wait_q      <= '0;
      pause_req_q <= 1'b0;
      hs_access_q <= 1'b0;
      hs_we_q     <= 1'b0;
      hs_addr_q   <= '0;
      hs_di_q     <= '0;
      buf_addr_q  <= '0;
      buf_we_q    <= 1'b0;
      buf_d_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hs_we_q  <= 1'b0;
      buf_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (pause_lost) begin
        // Busy stays up through the error pulse; IDLE clears it.
        state_q     <= StIdle;
        hs_access_q <= 1'b0;
        pause_req_q <= 1'b0;
        err_q       <= 1'b1;
      end else if (store_now) begin
        buf_addr_q <= idx_q;
        buf_d_q    <= I_HS_DO;
        buf_we_q   <= 1'b1;
        state_q    <= StSStore;
      end else begin
        unique case (state_q)
          StIdle: begin
            busy_q <= 1'b0;
            if (I_SAVE_REQ || I_LOAD_REQ) begin
              load_q      <= !I_SAVE_REQ;
              idx_q       <= '0;
              buf_addr_q  <= '0;
              pause_req_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= StPwait;
            end
          end
          StPwait: begin
            if (I_PAUSED) begin
              hs_access_q <= 1'b1;
              hs_addr_q   <= HS_BASE + {6'd0, idx_q};
              state_q     <= load_q ? StLFetch : StSAddr;
            end
          end
          StSAddr: begin
            wait_q  <= '0;
            state_q <= StSWait;
          end
          StSWait: begin
            wait_q <= wait_q + 2'd1;
          end
          StLFetch: begin
            hs_addr_q  <= HS_BASE + {6'd0, idx_q};
            hs_di_q    <= I_BUF_Q;
            hs_we_q    <= 1'b1;
            // The buffer read is registered, so the next byte's address goes out now.
            buf_addr_q <= idx_next;
            state_q    <= StLWrite;
          end
          StSStore, StLWrite: begin
            idx_q <= idx_next;
            if (last_byte) begin
              hs_access_q <= 1'b0;
              pause_req_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StFin;
            end else if (load_q) begin
              state_q <= StLFetch;
            end else begin
              hs_addr_q <= HS_BASE + {6'd0, idx_next};
              state_q   <= StSAddr;
            end
          end
          StFin: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign O_PAUSE_REQ = pause_req_q;
  assign O_HS_ADDR   = hs_addr_q;
  assign O_HS_DI     = hs_di_q;
  assign O_HS_WE     = hs_we_q;
  assign O_HS_ACCESS = hs_access_q;
  assign O_BUF_ADDR  = buf_addr_q;
  assign O_BUF_WE    = buf_we_q;
  assign O_BUF_D     = buf_d_q;
  assign O_BUSY      = busy_q;
  assign O_DONE      = done_q;
  assign O_ERR       = err_q;

endmodule
